// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl : pipeline sequencing controller for the 5-stage RV32I core
//             (if -> if_id -> id -> id_ex -> ex).
//
// Decides every cycle whether the front of the pipe advances, stalls or is
// flushed:
//   - load-use hazard : one-cycle stall of pc/if_id plus a bubble into id_ex
//   - jump/branch     : redirect pc and squash if_id and id_ex
//   - multi-cycle MDU : freeze pc, if_id and id_ex until mdu_done_i arrives,
//                       or until the wait counter reaches MDU_TIMEOUT
// A saturating counter records how many cycles had any hold asserted.
//
// Parameters
//   MDU_TIMEOUT : maximum cycles spent in WAIT before a forced abort
//   CNT_W       : width of the stall performance counter
//
// Ports
//   clk, rst            : core clock, synchronous active-low reset
//   id_rs1/rs2_addr_i   : source registers of the instruction in id
//                         (0 for unused operands)
//   ex_rd_addr_i        : destination of the instruction in ex
//   ex_load_i           : instruction in ex is a load
//   ex_reg_wen_i        : instruction in ex writes the register file
//   jump_en_i/addr_i    : taken branch/jal/jalr resolved in ex, and target
//   mdu_start_i         : ex issues a multi-cycle op this cycle
//   mdu_done_i          : MDU result valid this cycle
//   hold_*_o            : freeze pc / if_id / id_ex
//   flush_*_o           : load NOP into if_id / id_ex
//   jump_en_o/addr_o    : pc redirect
//   mdu_busy_o          : controller waiting on the MDU
//   mdu_err_o           : one-cycle pulse after a timeout abort
//   stall_cnt_o         : saturating count of cycles with any hold asserted
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic [4:0]       ex_rd_addr_i,
   input  logic             ex_load_i,
   input  logic             ex_reg_wen_i,
   input  logic             jump_en_i,
   input  logic [31:0]      jump_addr_i,
   input  logic             mdu_start_i,
   input  logic             mdu_done_i,
   output logic             hold_pc_o,
   output logic             hold_if_id_o,
   output logic             hold_id_ex_o,
   output logic             flush_if_id_o,
   output logic             flush_id_ex_o,
   output logic             jump_en_o,
   output logic [31:0]      jump_addr_o,
   output logic             mdu_busy_o,
   output logic             mdu_err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int WCW = (MDU_TIMEOUT < 1) ? 1 : $clog2(MDU_TIMEOUT + 1);
   localparam logic [WCW-1:0]   TIMEOUT_V = WCW'(MDU_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WCW-1:0]   r_wcnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_mdu_err;

   logic             w_luh;
   logic             w_mdu_multi;
   logic             w_timeout;
   logic             w_wait_exit;
   logic             w_hold_pc;
   logic             w_hold_if_id;
   logic             w_hold_id_ex;
   logic             w_flush_if_id;
   logic             w_flush_id_ex;
   logic             w_jump_en;
   logic [31:0]      w_jump_addr;
   logic             w_busy;
   logic             w_any_hold;

   // id drives x0 for unused operands, and x0 is never a real dependency,
   // so a plain address match is enough.
   assign w_luh = ex_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) &
                  ((ex_rd_addr_i == id_rs1_addr_i) |
                   (ex_rd_addr_i == id_rs2_addr_i));

   // start with done in the same cycle is a single-cycle op: no wait needed
   assign w_mdu_multi = mdu_start_i & ~mdu_done_i;

   // done on the timeout cycle is a normal completion, not an abort
   assign w_timeout   = (r_wcnt == TIMEOUT_V) & ~mdu_done_i;
   assign w_wait_exit = mdu_done_i | (r_wcnt == TIMEOUT_V);

   always_comb begin
      w_hold_pc     = 1'b0;
      w_hold_if_id  = 1'b0;
      w_hold_id_ex  = 1'b0;
      w_flush_if_id = 1'b0;
      w_flush_id_ex = 1'b0;
      w_jump_en     = 1'b0;
      w_jump_addr   = 32'd0;
      w_busy        = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (jump_en_i) begin
               // the dependent instruction is squashed, so luh is moot
               w_jump_en     = 1'b1;
               w_jump_addr   = jump_addr_i;
               w_flush_if_id = 1'b1;
               w_flush_id_ex = 1'b1;
            end else if (w_mdu_multi) begin
               w_hold_pc    = 1'b1;
               w_hold_if_id = 1'b1;
               w_hold_id_ex = 1'b1;
            end else if (w_luh) begin
               // the load leaves ex next cycle, so one bubble suffices
               w_hold_pc     = 1'b1;
               w_hold_if_id  = 1'b1;
               w_flush_id_ex = 1'b1;
            end
         end
         ST_WAIT: begin
            // redirects, new starts and hazards are all frozen behind the MDU
            if (!w_wait_exit) begin
               w_hold_pc    = 1'b1;
               w_hold_if_id = 1'b1;
               w_hold_id_ex = 1'b1;
               w_busy       = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Flush has priority over hold on the same register. The decode above
   // never produces both, but the pipeline registers see a clean encoding
   // regardless.
   assign hold_pc_o     = w_hold_pc;
   assign hold_if_id_o  = w_hold_if_id & ~w_flush_if_id;
   assign hold_id_ex_o  = w_hold_id_ex & ~w_flush_id_ex;
   assign flush_if_id_o = w_flush_if_id;
   assign flush_id_ex_o = w_flush_id_ex;
   assign jump_en_o     = w_jump_en;
   assign jump_addr_o   = w_jump_addr;
   assign mdu_busy_o    = w_busy;
   assign mdu_err_o     = r_mdu_err;
   assign stall_cnt_o   = r_stall_cnt;

   assign w_any_hold = hold_pc_o | hold_if_id_o | hold_id_ex_o;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_wcnt      <= '0;
         r_stall_cnt <= '0;
         r_mdu_err   <= 1'b0;
      end else begin
         r_mdu_err <= 1'b0;

         if (w_any_hold && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);

         case (r_state)
            ST_RUN: begin
               // the start cycle itself counts as the first wait cycle
               if (!jump_en_i && w_mdu_multi) begin
                  r_state <= ST_WAIT;
                  r_wcnt  <= WCW'(1);
               end
            end
            ST_WAIT: begin
               if (w_wait_exit) begin
                  r_state   <= ST_RUN;
                  r_wcnt    <= '0;
                  r_mdu_err <= w_timeout;
               end else begin
                  r_wcnt <= r_wcnt + WCW'(1);
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_wcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl : self-checking bench for pipe_ctrl.
// Two instances share one stimulus stream: A uses the default parameters,
// B uses MDU_TIMEOUT=4 / CNT_W=4 so timeout and counter saturation are
// reachable quickly. Each instance is tracked by its own cycle-level model.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [4:0]  rs1, rs2, rd;
   logic        ld, wen, jen, st, dn;
   logic [31:0] jaddr;

   logic        a_hpc, a_hif, a_hex, a_fif, a_fex, a_jen, a_busy, a_err;
   logic [31:0] a_jaddr, a_stall;
   logic        b_hpc, b_hif, b_hex, b_fif, b_fex, b_jen, b_busy, b_err;
   logic [31:0] b_jaddr;
   logic [3:0]  b_stall;

   pipe_ctrl dut_a (
      .clk(clk), .rst(rst),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .ex_rd_addr_i(rd),
      .ex_load_i(ld), .ex_reg_wen_i(wen),
      .jump_en_i(jen), .jump_addr_i(jaddr),
      .mdu_start_i(st), .mdu_done_i(dn),
      .hold_pc_o(a_hpc), .hold_if_id_o(a_hif), .hold_id_ex_o(a_hex),
      .flush_if_id_o(a_fif), .flush_id_ex_o(a_fex),
      .jump_en_o(a_jen), .jump_addr_o(a_jaddr),
      .mdu_busy_o(a_busy), .mdu_err_o(a_err), .stall_cnt_o(a_stall)
   );

   pipe_ctrl #(.MDU_TIMEOUT(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .ex_rd_addr_i(rd),
      .ex_load_i(ld), .ex_reg_wen_i(wen),
      .jump_en_i(jen), .jump_addr_i(jaddr),
      .mdu_start_i(st), .mdu_done_i(dn),
      .hold_pc_o(b_hpc), .hold_if_id_o(b_hif), .hold_id_ex_o(b_hex),
      .flush_if_id_o(b_fif), .flush_id_ex_o(b_fex),
      .jump_en_o(b_jen), .jump_addr_o(b_jaddr),
      .mdu_busy_o(b_busy), .mdu_err_o(b_err), .stall_cnt_o(b_stall)
   );

   // control vector bits: [7]hold_pc [6]hold_if_id [5]hold_id_ex
   // [4]flush_if_id [3]flush_id_ex [2]jump_en [1]busy [0]err
   wire [7:0] ctl_a = {a_hpc, a_hif, a_hex, a_fif, a_fex, a_jen, a_busy, a_err};
   wire [7:0] ctl_b = {b_hpc, b_hif, b_hex, b_fif, b_fex, b_jen, b_busy, b_err};

   int tests = 0;
   int fails = 0;

   // reference model state, index 0 = dut_a, 1 = dut_b
   int     TO   [2] = '{64, 4};
   longint SMAX [2] = '{64'hFFFF_FFFF, 64'd15};
   bit     m_wait  [2];
   int     m_waited[2];
   longint m_stall [2];
   bit     m_err   [2];

   task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   // One clock cycle: called just after a negedge with inputs already driven.
   task automatic step(bit do_chk);
      logic [7:0]  e  [2];
      logic [31:0] ea [2];
      bit luh;
      #1;
      luh = ld && wen && (rd != 0) && (rd == rs1 || rd == rs2);
      for (int k = 0; k < 2; k++) begin
         e[k]  = 8'd0;
         ea[k] = 32'd0;
         e[k][0] = m_err[k];
         if (!m_wait[k]) begin
            if (jen) begin
               e[k][4] = 1'b1; e[k][3] = 1'b1; e[k][2] = 1'b1; ea[k] = jaddr;
            end else if (st && !dn) begin
               e[k][7:5] = 3'b111;
            end else if (luh) begin
               e[k][7] = 1'b1; e[k][6] = 1'b1; e[k][3] = 1'b1;
            end
         end else if (!(dn || m_waited[k] == TO[k])) begin
            e[k][7:5] = 3'b111;
            e[k][1]   = 1'b1;
         end
      end
      if (do_chk) begin
         chk("ctl",   0, {24'd0, ctl_a}, {24'd0, e[0]});
         chk("ctl",   1, {24'd0, ctl_b}, {24'd0, e[1]});
         chk("jaddr", 0, a_jaddr, ea[0]);
         chk("jaddr", 1, b_jaddr, ea[1]);
         chk("stall", 0, a_stall, 32'(m_stall[0]));
         chk("stall", 1, {28'd0, b_stall}, 32'(m_stall[1]));
         chk("flush_hold_overlap", 0, {30'd0, a_fif & a_hif, a_fex & a_hex}, 32'd0);
         chk("flush_hold_overlap", 1, {30'd0, b_fif & b_hif, b_fex & b_hex}, 32'd0);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            m_wait[k] = 0; m_waited[k] = 0; m_stall[k] = 0; m_err[k] = 0;
         end else begin
            if (e[k][7] || e[k][6] || e[k][5])
               m_stall[k] = (m_stall[k] + 1 > SMAX[k]) ? SMAX[k] : m_stall[k] + 1;
            m_err[k] = m_wait[k] && !dn && (m_waited[k] == TO[k]);
            if (!m_wait[k]) begin
               if (!jen && st && !dn) begin m_wait[k] = 1; m_waited[k] = 1; end
            end else if (dn || m_waited[k] == TO[k]) begin
               m_wait[k] = 0; m_waited[k] = 0;
            end else begin
               m_waited[k]++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 1; rs1 = 0; rs2 = 0; rd = 0; ld = 0; wen = 0;
      jen = 0; jaddr = 0; st = 0; dn = 0;
   endtask

   initial begin
      idle();
      rst = 0;
      @(negedge clk);
      step(0);                       // clear the power-up state
      rst = 0; step(1);              // reset state checked
      idle(); step(1);

      // load-use hazard on rs2: one stall cycle, then clear
      ld = 1; wen = 1; rd = 5; rs2 = 5; step(1);
      idle(); step(1);
      // same hazard with rd=x0: no stall
      ld = 1; wen = 1; rd = 0; rs2 = 0; rs1 = 0; step(1);
      // hazard on rs1, but no writeback: no stall
      ld = 1; wen = 0; rd = 7; rs1 = 7; step(1);
      idle(); step(1);

      // jump with simultaneous hazard
      ld = 1; wen = 1; rd = 5; rs1 = 5; jen = 1; jaddr = 32'h8000_0040; step(1);
      idle(); step(1);

      // MDU start, done five cycles later (dut_b times out first)
      st = 1; step(1);
      idle();
      repeat (4) step(1);
      dn = 1; step(1);
      idle(); step(1); step(1);

      // single-cycle MDU op
      st = 1; dn = 1; step(1);
      idle(); step(1);

      // no done: both instances time out; jump in WAIT is ignored
      st = 1; step(1);
      idle(); step(1);
      jen = 1; jaddr = 32'h1234_5678; step(1);
      idle();
      repeat (68) step(1);

      // reset while waiting
      st = 1; step(1);
      idle(); step(1); step(1);
      rst = 0; step(1);
      idle(); step(1); step(1);

      // continuous hazard for 20 cycles: dut_b counter saturates at 4'hF
      ld = 1; wen = 1; rd = 9; rs1 = 9;
      repeat (20) step(1);
      idle(); step(1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 99) != 0);
         rs1   = 5'($urandom_range(0, 3));
         rs2   = 5'($urandom_range(0, 3));
         rd    = 5'($urandom_range(0, 3));
         ld    = ($urandom_range(0, 2) == 0);
         wen   = ($urandom_range(0, 3) != 0);
         jen   = ($urandom_range(0, 7) == 0);
         jaddr = $urandom;
         st    = ($urandom_range(0, 5) == 0);
         dn    = ($urandom_range(0, 9) == 0);
         step(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
